// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the RV32I core. Owns the program counter, fetches
// one instruction at a time over a request/valid handshake, presents the
// instruction and its decoded fields to the control unit, and selects the next
// PC from the sequential address or the ALU target. A misaligned control-flow
// target parks the unit in a terminal FAULT state until reset.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   imem_req/imem_addr   fetch request and address (address is always pc)
//   imem_rvalid/rdata    fetch response, only looked at in FETCH
//   advance              core finished the presented instruction (HOLD only)
//   PCSel/alu_target     next-PC selection from the control unit / ALU
//   instr_valid, instr   presented instruction
//   opcode/funct3/funct7 combinational slices of instr
//   pc, pc_plus4         current PC and its sequential successor
//   fault, fault_addr    sticky misaligned-target fault and offending target
//   instret              retired-instruction counter
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        PCSel,
    input  logic [31:0] alu_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] next_pc;

    // Sequential successor wraps naturally at 2^32.
    assign pc_plus4_w = pc_q + 32'd4;

    // Next-state and next-value logic. Each register holds its value unless
    // the current state explicitly updates it. Bit 0 of a taken target is
    // cleared so JALR targets land on a halfword boundary; bit 1 set after
    // that means the target is not word aligned and is treated as a fault.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        fault_addr_d = fault_addr_q;
        instret_d    = instret_q;
        next_pc      = PCSel ? (alu_target & 32'hFFFF_FFFE) : pc_plus4_w;

        case (state_q)
            ST_FETCH: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    if (next_pc[1]) begin
                        fault_addr_d = next_pc;
                        state_d      = ST_FAULT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register. Reset wins over everything, so a response that lands
    // in the reset cycle is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            fault_addr_q <= 32'd0;
            instret_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            fault_addr_q <= fault_addr_d;
            instret_q    <= instret_d;
        end
    end

    // Handshake and status outputs are gated by rst_n so they read as idle
    // for the whole cycle in which reset is being applied.
    assign imem_req    = rst_n && (state_q == ST_FETCH);
    assign instr_valid = rst_n && (state_q == ST_HOLD);
    assign fault       = rst_n && (state_q == ST_FAULT);

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_w;
    assign instr      = instr_q;
    assign opcode     = instr_q[6:0];
    assign funct3     = instr_q[14:12];
    assign funct7     = instr_q[30];
    assign fault_addr = fault_addr_q;
    assign instret    = instret_q;

endmodule
